// File: rtl/song_pkg.sv
// Shared constants and the playback state type for the song sequencer.
package song_pkg;

  localparam int NOTE_IDX_W = 11;
  localparam int PITCH_W    = 7;
  localparam logic [PITCH_W-1:0] REST_PITCH = 7'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_END   = 2'd3
  } state_e;

endpackage

// File: rtl/song_note_timer.sv
// Per-note duration countdown in beat ticks. A zero duration is loaded as
// one tick so every note sounds for at least one beat. expire flags the tick
// that consumes the final remaining count.
module song_note_timer #(
  parameter int DUR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             tick,
  input  logic             pause,
  output logic             expire,
  output logic [DUR_W-1:0] remaining
);

  logic [DUR_W-1:0] rem_q;
  logic [DUR_W-1:0] rem_d;

  // Next count: clear beats load beats an unpaused tick.
  always_comb begin
    rem_d = rem_q;
    if (clear) begin
      rem_d = '0;
    end else if (load) begin
      rem_d = (load_val == '0) ? DUR_W'(1) : load_val;
    end else if (tick && !pause && (rem_q != '0)) begin
      rem_d = rem_q - DUR_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign expire    = tick && !pause && (rem_q == DUR_W'(1));
  assign remaining = rem_q;

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks a combinational pitch/duration table from index 0 to
// last_index, one note per FETCH/PLAY pair, timed by beat ticks.
// Build option: define SONG_LOOP_EN to restart at index 0 after the last note
// (done still pulses) instead of returning to IDLE.
//
// Control inputs are plain pulses/levels sampled on each rising edge; there
// is no handshake. stop beats start, reset beats everything.
module song_sequencer
  import song_pkg::*;
#(
  parameter int DUR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic [NOTE_IDX_W-1:0] last_index,
  output logic [NOTE_IDX_W-1:0] note_index,
  input  logic [PITCH_W-1:0]    note_pitch,
  input  logic [DUR_W-1:0]      note_dur,
  output logic [PITCH_W-1:0]    pitch_out,
  output logic                  note_on,
  output logic                  busy,
  output logic                  done,
  output state_e                dbg_state
);

  state_e                state_q, state_d;
  logic [NOTE_IDX_W-1:0] idx_q, idx_d;
  logic [PITCH_W-1:0]    pitch_q, pitch_d;
  logic                  note_on_q, note_on_d;
  logic                  done_q, done_d;
  logic                  tmr_load, tmr_clear, tmr_expire;
  logic [DUR_W-1:0]      tmr_remaining;

  song_note_timer #(.DUR_W(DUR_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (tmr_clear),
    .load      (tmr_load),
    .load_val  (note_dur),
    .tick      (tick),
    .pause     (pause),
    .expire    (tmr_expire),
    .remaining (tmr_remaining)
  );

  // Next-state and output decode; note_on lags the state by one cycle, which
  // yields the one-cycle articulation gap after each FETCH.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pitch_d   = pitch_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    note_on_d = (pitch_q != REST_PITCH) && !pause && (state_q == ST_PLAY);
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        pitch_d  = note_pitch;
        tmr_load = 1'b1;
        state_d  = ST_PLAY;
      end
      ST_PLAY: begin
        if (tmr_expire) begin
          if (idx_q < last_index) begin
            idx_d   = idx_q + NOTE_IDX_W'(1);
            state_d = ST_FETCH;
          end else begin
            done_d = 1'b1;
`ifdef SONG_LOOP_EN
            idx_d   = '0;
            state_d = ST_FETCH;
`else
            state_d = ST_END;
`endif
          end
        end
      end
      ST_END: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      note_on_d = 1'b0;
      done_d    = 1'b0;
      tmr_load  = 1'b0;
      tmr_clear = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pitch_q   <= '0;
      note_on_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pitch_q   <= pitch_d;
      note_on_q <= note_on_d;
      done_q    <= done_d;
    end
  end

  assign note_index = idx_q;
  assign pitch_out  = pitch_q;
  assign note_on    = note_on_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter DUR_W, default 8, width of the per-note duration in beat ticks.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick  input  1  one-cycle beat-tick pulse, the time base for note durations.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins playback at index 0.
REQ-006 SHALL have port stop  input  1  one-cycle pulse; aborts playback.
REQ-007 SHALL have port pause  input  1  level; while high, playback is frozen and muted.
REQ-008 SHALL have port last_index  input  11  index of the final note of the song (static during playback).
REQ-009 SHALL have port note_index  output  11  address driven to the combinational song pitch/duration tables.
REQ-010 SHALL have port note_pitch  input  7  MIDI pitch returned for note_index; 0 = rest.
REQ-011 SHALL have port note_dur  input  DUR_W  duration in ticks returned for note_index.
REQ-012 SHALL have port pitch_out  output  7  registered pitch of the sounding note, to the tone generator.
REQ-013 SHALL have port note_on  output  1  high while a non-rest note sounds and pause is low.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the song ends naturally.

Function
REQ-016 SHALL implement states IDLE, FETCH, PLAY, END.
REQ-017 IDLE: note_index=0, note_on=0; start -> FETCH next cycle.
REQ-018 FETCH (exactly 1 cycle): pitch_out<=note_pitch; remaining<=note_dur, with note_dur=0 loaded as 1; -> PLAY.
REQ-019 note_on SHALL be registered as (pitch_out!=0) && !pause && state==PLAY; start pulse to note_on high = 3 cycles for a non-rest first note.
REQ-020 PLAY: tick with pause low decrements remaining; tick while remaining==1 ends the note.
REQ-021 Note end with note_index<last_index: note_index+1, -> FETCH; note_on SHALL drop for the FETCH cycle (articulation gap).
REQ-022 Note end with note_index==last_index: -> END; END asserts done for one cycle, then -> IDLE with note_index=0.
REQ-023 tick while pause high SHALL be ignored; remaining and note_index hold.
REQ-024 stop in any state SHALL force IDLE next cycle, note_on=0, note_index=0, no done pulse.
REQ-025 stop and start in the same cycle: stop wins.
REQ-026 start while busy SHALL be ignored.
REQ-027 Index arithmetic SHALL be 11-bit unsigned; last_index=2047 SHALL play all 2048 entries without wrap error.

Reset
REQ-028 reset SHALL force IDLE, note_index=0, pitch_out=0, remaining=0, note_on=0, busy=0, done=0 on the next edge, overriding all other inputs, including mid-note.

Configuration
REQ-029 With SONG_LOOP_EN defined, end of last note SHALL instead reload note_index=0 and go to FETCH, pulsing done for one cycle, never returning to IDLE except via stop/reset.
REQ-030 Without SONG_LOOP_EN, behaviour SHALL be per REQ-022.

Structure
REQ-031 Package song_pkg SHALL hold NOTE_IDX_W=11, PITCH_W=7, REST_PITCH=0 and the state enum type.
REQ-032 Duration countdown SHALL be a sub-module song_note_timer (load, tick, pause, expire).

Verification
REQ-033 last_index=2, pitches {60,0,61}, durs {2,1,3}, tick every 4 cycles: note_on high/low/high with pitch_out 60,0,61; done once; IDLE.
REQ-034 note_dur=0 at index 0: note plays for exactly 1 tick.
REQ-035 pause high for 3 ticks mid-note: note_on low, note_index and remaining unchanged; resume completes remaining ticks.
REQ-036 stop asserted in PLAY at index 5: next cycle IDLE, note_index=0, note_on=0, no done.
REQ-037 start and stop same cycle in IDLE: stays IDLE; reset mid-note: all outputs zero next edge.
REQ-038 SONG_LOOP_EN defined, last_index=1: after index 1 ends, done pulses, note_index returns to 0, busy stays high.
